// File: rtl/calc_sequencer_pkg.sv
// calc_sequencer_pkg: shared constants for the calculator arithmetic path
//   operator codes, display range limits, error code, FSM encodings, magnitude helper
package calc_sequencer_pkg;
    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [2:0] OP_MUL = 3'd1;
    localparam logic [2:0] OP_DIV = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_MOD = 3'd5;
    localparam logic [WIDTH-1:0] ERR_CODE = 32'h00EE_0000;
    // one guard bit above WIDTH so wrapped add/sub and unsigned magnitudes compare correctly
    localparam logic signed [WIDTH:0] MAX_POS = 33'sd999999;
    localparam logic signed [WIDTH:0] MIN_NEG = -33'sd99999;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FIX   = 2'd2;
    localparam logic [1:0] S_CHECK = 2'd3;
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction
endpackage

// File: rtl/calc_iter_core.sv
// calc_iter_core: unsigned one-bit-per-cycle shift-add multiplier / restoring divider
//   clock_50m, rst (async active-low); load clears state; step advances one bit at idx
//   (MSB first); div_mode selects divide; a/b magnitudes; prod, quo, rem results
module calc_iter_core
    import calc_sequencer_pkg::*;
(
    input  logic               clock_50m,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               div_mode,
    input  logic [CNT_W-1:0]   idx,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] prod,
    output logic [WIDTH-1:0]   quo,
    output logic [WIDTH-1:0]   rem
);
    logic [WIDTH:0] trial;
    logic fits;
    assign trial = {rem, a[idx]};
    assign fits = trial >= {1'b0, b};
    always_ff @(posedge clock_50m or negedge rst) begin
        if (!rst) begin
            prod <= '0;
            quo  <= '0;
            rem  <= '0;
        end else if (load) begin
            prod <= '0;
            quo  <= '0;
            rem  <= '0;
        end else if (step && div_mode) begin
            rem <= fits ? WIDTH'(trial - {1'b0, b}) : trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], fits};
        end else if (step) begin
            prod <= {prod[2*WIDTH-2:0], 1'b0} + (b[idx] ? {{WIDTH{1'b0}}, a} : '0);
        end
    end
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: multi-cycle signed calculator controller with error detection
//   clock_50m, rst (async active-low); start pulse samples operand1/operand2/operator;
//   busy while computing; done pulse with ans/err (err forces ans = ERR_CODE), held until next done
module calc_sequencer
    import calc_sequencer_pkg::*;
(
    input  logic             clock_50m,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [2:0]       operator,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ans,
    output logic             err
);
    logic [1:0] state, state_nx;
    logic [2:0] op_q;
    logic [WIDTH-1:0] o1_q, o2_q, quo, rem;
    logic [2*WIDTH-1:0] prod;
    logic [CNT_W-1:0] cnt;
    logic sign_q, sign_r, iter_op, legal, err_c;
    logic signed [WIDTH:0] sx1, sx2, mag_p, mag_q, mag_r, res;

    assign sign_q = o1_q[WIDTH-1] ^ o2_q[WIDTH-1];
    assign sign_r = o1_q[WIDTH-1];
    assign iter_op = op_q == OP_MUL || op_q == OP_DIV || op_q == OP_MOD;
    assign legal = iter_op || op_q == OP_ADD || op_q == OP_SUB;
    assign state_nx = state == S_IDLE ? (start ? S_RUN : S_IDLE)
                    : state == S_RUN  ? ((iter_op && cnt != '0) ? S_RUN : S_FIX)
                    : state == S_FIX  ? S_CHECK : S_IDLE;
    assign busy = state == S_RUN || state == S_FIX;
    assign done = state == S_CHECK;

    calc_iter_core u_core (
        .clock_50m (clock_50m),
        .rst       (rst),
        .load      (state == S_IDLE && start),
        .step      (state == S_RUN && iter_op),
        .div_mode  (op_q != OP_MUL),
        .idx       (cnt),
        .a         (mag(o1_q)),
        .b         (mag(o2_q)),
        .prod      (prod),
        .quo       (quo),
        .rem       (rem)
    );

    // all results are widened by one bit so range checks see true values, not wrapped ones
    assign sx1 = {o1_q[WIDTH-1], o1_q};
    assign sx2 = {o2_q[WIDTH-1], o2_q};
    assign mag_p = {1'b0, prod[WIDTH-1:0]};
    assign mag_q = {1'b0, quo};
    assign mag_r = {1'b0, rem};
    assign res = op_q == OP_ADD ? sx1 + sx2
               : op_q == OP_SUB ? sx1 - sx2
               : op_q == OP_MUL ? (sign_q ? -mag_p : mag_p)
               : op_q == OP_DIV ? (sign_q ? -mag_q : mag_q)
               : (sign_r ? -mag_r : mag_r);
    assign err_c = !legal || ((op_q == OP_DIV || op_q == OP_MOD) && o2_q == '0)
                 || res > MAX_POS || res < MIN_NEG
                 || (op_q == OP_MUL && |prod[2*WIDTH-1:WIDTH]);

    always_ff @(posedge clock_50m or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= '0;
            o1_q  <= '0;
            o2_q  <= '0;
            ans   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start) begin
                op_q <= operator;
                o1_q <= operand1;
                o2_q <= operand2;
                cnt  <= CNT_W'(WIDTH - 1);
            end
            if (state == S_RUN && iter_op && cnt != '0) cnt <= cnt - 1'b1;
            if (state == S_FIX) begin
                ans <= err_c ? ERR_CODE : res[WIDTH-1:0];
                err <= err_c;
            end
        end
    end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: scoreboard bench for calc_sequencer
module tb_calc_sequencer;
    localparam int ERR = 32'h00EE_0000;

    typedef struct {
        logic [31:0] ans;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        int         a;
        int         b;
        logic [2:0] op;
        int         ans;
        logic       err;
    } vec_t;

    logic clock_50m = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic [31:0] operand1 = '0;
    logic [31:0] operand2 = '0;
    logic [2:0] operator = '0;
    logic busy, done, err;
    logic [31:0] ans;
    int errors = 0;
    int checks = 0;
    exp_t sb[$];

    vec_t vecs[25] = '{
        '{10, 101, 3'd3, 111, 1'b0},
        '{10, 101, 3'd4, -91, 1'b0},
        '{10, 101, 3'd1, 1010, 1'b0},
        '{10, 101, 3'd2, 0, 1'b0},
        '{10, 101, 3'd5, 10, 1'b0},
        '{-10, 101, 3'd3, 91, 1'b0},
        '{-10, 101, 3'd4, -111, 1'b0},
        '{-10, 101, 3'd1, -1010, 1'b0},
        '{-10, 101, 3'd2, 0, 1'b0},
        '{-10, 101, 3'd5, -10, 1'b0},
        '{-10, -101, 3'd2, 0, 1'b0},
        '{-10, -101, 3'd5, -10, 1'b0},
        '{100000, -500, 3'd1, ERR, 1'b1},
        '{100000, -500, 3'd2, -200, 1'b0},
        '{100000, -500, 3'd5, 0, 1'b0},
        '{1023, 0, 3'd2, ERR, 1'b1},
        '{1023, 0, 3'd5, ERR, 1'b1},
        '{999999, 0, 3'd3, 999999, 1'b0},
        '{999999, 1, 3'd3, ERR, 1'b1},
        '{-99999, 0, 3'd4, -99999, 1'b0},
        '{-99999, 1, 3'd4, ERR, 1'b1},
        '{5, 5, 3'd0, ERR, 1'b1},
        '{5, 5, 3'd7, ERR, 1'b1},
        '{-7, 3, 3'd1, -21, 1'b0},
        '{2147483647, 2147483647, 3'd3, ERR, 1'b1}
    };

    calc_sequencer dut (
        .clock_50m (clock_50m),
        .rst       (rst),
        .start     (start),
        .operand1  (operand1),
        .operand2  (operand2),
        .operator  (operator),
        .busy      (busy),
        .done      (done),
        .ans       (ans),
        .err       (err)
    );

    always #5 clock_50m = ~clock_50m;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int lat_of(input logic [2:0] op);
        return (op == 3'd1 || op == 3'd2 || op == 3'd5) ? 34 : 3;
    endfunction

    // reference arithmetic in 64-bit integers, independent of any bit-serial scheme
    function automatic exp_t model(input int a, input int b, input logic [2:0] op);
        longint r;
        exp_t e;
        logic bad;
        r = 0;
        bad = !(op >= 3'd1 && op <= 3'd5) || ((op == 3'd2 || op == 3'd5) && b == 0);
        if (!bad)
            r = op == 3'd1 ? longint'(a) * b : op == 3'd2 ? longint'(a / b)
              : op == 3'd3 ? longint'(a) + b : op == 3'd4 ? longint'(a) - b : longint'(a % b);
        bad = bad || r > 999999 || r < -99999;
        e.ans = bad ? ERR : 32'(r);
        e.err = bad;
        e.lat = lat_of(op);
        return e;
    endfunction

    task automatic send(input int a, input int b, input logic [2:0] op);
        @(negedge clock_50m);
        operand1 = a;
        operand2 = b;
        operator = op;
        start = 1'b1;
        @(posedge clock_50m);
        #1;
        start = 1'b0;
        operand1 = $urandom;
        operand2 = $urandom;
        operator = 3'($urandom);
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clock_50m);
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clock_50m);
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        if (ans !== 32'd0) begin errors++; $display("FAIL reset_ans got %h want 0", ans); end
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        rst = 1'b1;
    endtask

    task automatic test_arith;
        int cyc;
        exp_t e;
        foreach (vecs[k]) begin
            sb.push_back('{32'(vecs[k].ans), vecs[k].err, lat_of(vecs[k].op)});
            send(vecs[k].a, vecs[k].b, vecs[k].op);
            wait_done(cyc);
            e = sb.pop_front();
            checks += 3;
            if (cyc != e.lat) begin errors++; $display("FAIL arith_lat[%0d] got %0d want %0d", k, cyc, e.lat); end
            if (ans !== e.ans) begin errors++; $display("FAIL arith_ans[%0d] got %0d want %0d", k, $signed(ans), $signed(e.ans)); end
            if (err !== e.err) begin errors++; $display("FAIL arith_err[%0d] got %b want %b", k, err, e.err); end
        end
    endtask

    task automatic test_random;
        int a, b, cyc;
        logic [2:0] op;
        exp_t e;
        for (int k = 0; k < 12; k++) begin
            a = int'($urandom_range(4000)) - 2000;
            b = int'($urandom_range(4000)) - 2000;
            op = 3'($urandom_range(7));
            sb.push_back(model(a, b, op));
            send(a, b, op);
            wait_done(cyc);
            e = sb.pop_front();
            checks += 3;
            if (cyc != e.lat) begin errors++; $display("FAIL rand_lat[%0d] op=%0d got %0d want %0d", k, op, cyc, e.lat); end
            if (ans !== e.ans) begin errors++; $display("FAIL rand_ans[%0d] %0d op%0d %0d got %0d want %0d", k, a, op, b, $signed(ans), $signed(e.ans)); end
            if (err !== e.err) begin errors++; $display("FAIL rand_err[%0d] got %b want %b", k, err, e.err); end
        end
    endtask

    task automatic test_ignore_start;
        int ndone, cyc;
        exp_t e;
        ndone = 0;
        cyc = -1;
        sb.push_back('{32'd142, 1'b0, 34});
        send(1000, 7, 3'd2);
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock_50m);
            if (i == 1) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy got %b want 1", busy); end
            end
            start = (i == 1 || i == 10);
            operand1 = 3;
            operand2 = 4;
            operator = 3'd3;
            if (done) begin
                ndone++;
                if (cyc < 0) begin
                    cyc = i;
                    e = sb.pop_front();
                    checks += 2;
                    if (ans !== e.ans) begin errors++; $display("FAIL ignore_ans got %0d want %0d", $signed(ans), $signed(e.ans)); end
                    if (cyc != e.lat) begin errors++; $display("FAIL ignore_lat got %0d want %0d", cyc, e.lat); end
                end
            end
        end
        start = 1'b0;
        checks++;
        if (ndone != 1) begin errors++; $display("FAIL ignore_ndone got %0d want 1", ndone); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        exp_t e;
        sb.push_back('{32'd42, 1'b0, 3});
        send(40, 2, 3'd3);
        wait_done(cyc);
        e = sb.pop_front();
        checks++;
        if (ans !== e.ans) begin errors++; $display("FAIL b2b_first_ans got %0d want %0d", $signed(ans), $signed(e.ans)); end
        // start during the done cycle must be dropped
        start = 1'b1;
        operand1 = 1;
        operand2 = 1;
        operator = 3'd3;
        @(posedge clock_50m);
        #1;
        start = 1'b0;
        checks += 3;
        if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_width got %b want 0", done); end
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_check_start busy got %b want 0", busy); end
        if (ans !== 32'd42) begin errors++; $display("FAIL b2b_hold got %0d want 42", $signed(ans)); end
        // first IDLE cycle after done: must be accepted
        sb.push_back('{-32'sd2, 1'b0, 3});
        operand1 = 7;
        operand2 = 9;
        operator = 3'd4;
        start = 1'b1;
        @(posedge clock_50m);
        #1;
        start = 1'b0;
        wait_done(cyc);
        e = sb.pop_front();
        checks += 2;
        if (cyc != e.lat) begin errors++; $display("FAIL b2b_lat got %0d want %0d", cyc, e.lat); end
        if (ans !== e.ans) begin errors++; $display("FAIL b2b_ans got %0d want %0d", $signed(ans), $signed(e.ans)); end
    endtask

    task automatic test_reset_mid;
        int ndone, cyc;
        exp_t e;
        send(123, 45, 3'd1);
        repeat (5) @(negedge clock_50m);
        rst = 1'b0;
        #1;
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL mid_done got %b want 0", done); end
        if (ans !== 32'd0) begin errors++; $display("FAIL mid_ans got %0d want 0", $signed(ans)); end
        if (err !== 1'b0) begin errors++; $display("FAIL mid_err got %b want 0", err); end
        @(negedge clock_50m);
        rst = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clock_50m);
            if (done) ndone++;
        end
        checks++;
        if (ndone != 0) begin errors++; $display("FAIL mid_no_done got %0d want 0", ndone); end
        sb.push_back('{32'd5535, 1'b0, 34});
        send(123, 45, 3'd1);
        wait_done(cyc);
        e = sb.pop_front();
        checks += 3;
        if (cyc != e.lat) begin errors++; $display("FAIL mid_after_lat got %0d want %0d", cyc, e.lat); end
        if (ans !== e.ans) begin errors++; $display("FAIL mid_after_ans got %0d want %0d", $signed(ans), $signed(e.ans)); end
        if (err !== e.err) begin errors++; $display("FAIL mid_after_err got %b want %b", err, e.err); end
    endtask

    initial begin
        test_reset;
        test_arith;
        test_random;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
